// File: rtl/img_scale_pkg.sv
// Shared types for the image-scaling datapath.
// Divider state encoding and a width helper.
package img_scale_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIV,
    S_FIX,
    S_DONE
  } div_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/fxp_ratio_divider_if.sv
// Operand/result handshake bundle for the ratio divider.
// slave is the divider side, master the requester side.
interface fxp_ratio_divider_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_r;
  logic [TAG_W-1:0] out_tag;
  logic             out_dbz;
  logic             out_ovf;

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  in_tag,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_q,
    output out_r,
    output out_tag,
    output out_dbz,
    output out_ovf
  );

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output in_tag,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_q,
    input  out_r,
    input  out_tag,
    input  out_dbz,
    input  out_ovf
  );

endinterface

// File: rtl/fxp_div_step.sv
// One restoring-division iteration: shift in a
// dividend bit, compare against the divisor, subtract.
module fxp_div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   rem_cur,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH:0]   rem_nxt,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // A set top bit means the shifted value exceeds
  // any WIDTH-bit divisor, so the subtract is taken.
  always_comb begin
    shifted = {rem_cur[WIDTH-1:0], dvd_bit};
    diff    = shifted - {1'b0, dvsr};
    q_bit   = rem_cur[WIDTH]
            | (shifted >= {1'b0, dvsr});
    rem_nxt = q_bit ? diff : shifted;
  end

endmodule

// File: rtl/fxp_ratio_divider.sv
// Multi-cycle fixed-point ratio divider:
// Q = (A << FRAC_BITS) / B with remainder and flags.
module fxp_ratio_divider
  import img_scale_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 8,
  parameter int SIGNED    = 0,
  parameter int TAG_W     = 4
) (
  input logic              clk,
  input logic              reset,
  fxp_ratio_divider_if.slave bus
);

  localparam int N  = WIDTH + FRAC_BITS;
  localparam int CW = clog2(N + 1);

  localparam logic [N:0] U_LIM =
    (N+1)'({1'b1, {WIDTH{1'b0}}});
  localparam logic [N-1:0] POS_LIM =
    N'({(WIDTH-1){1'b1}});
  localparam logic [N-1:0] NEG_LIM =
    POS_LIM + N'(1);
  localparam logic [WIDTH-1:0] SMAX =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN =
    {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t state;
  div_state_t state_nxt;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [TAG_W-1:0] tag_q;
  logic [WIDTH-1:0] mag_b;
  logic [N-1:0]     dvd;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             neg_a;
  logic             dbz_q;

  logic [WIDTH-1:0] q_o;
  logic [WIDTH-1:0] r_o;
  logic [TAG_W-1:0] tag_o;
  logic             dbz_o;
  logic             ovf_o;

  logic             a_neg_c;
  logic             b_neg_c;
  logic [WIDTH-1:0] mag_a_c;
  logic [WIDTH-1:0] mag_b_c;
  logic [N-1:0]     dvd_load;
  logic [WIDTH:0]   rem_step;
  logic             q_bit;

  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] sat;
  logic             ovf_fix;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  fxp_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_cur (rem),
    .dvd_bit (dvd[N-1]),
    .dvsr    (mag_b),
    .rem_nxt (rem_step),
    .q_bit   (q_bit)
  );

  always_comb begin
    a_neg_c  = (SIGNED != 0) && a_q[WIDTH-1];
    b_neg_c  = (SIGNED != 0) && b_q[WIDTH-1];
    mag_a_c  = a_neg_c ? -a_q : a_q;
    mag_b_c  = b_neg_c ? -b_q : b_q;
    dvd_load = '0;
    dvd_load[N-1 -: WIDTH] = mag_a_c;
  end

  // dvd doubles as the quotient register: dividend
  // bits leave at the top as quotient bits enter below.
  always_comb begin
    q_mag   = dvd[WIDTH-1:0];
    sat     = '1;
    ovf_fix = 1'b0;
    if (SIGNED != 0) begin
      sat     = neg_q ? SMIN : SMAX;
      ovf_fix = neg_q ? (dvd > NEG_LIM)
                      : (dvd > POS_LIM);
    end else begin
      ovf_fix = {1'b0, dvd} >= U_LIM;
    end
    q_fix = ovf_fix ? sat
          : (neg_q ? -q_mag : q_mag);
    r_fix = neg_a ? -rem[WIDTH-1:0]
                  : rem[WIDTH-1:0];
    if (dbz_q) begin
      ovf_fix = 1'b0;
      q_fix   = (SIGNED == 0) ? '1
              : (neg_a ? SMIN : SMAX);
      r_fix   = a_q;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (bus.in_valid) state_nxt = S_LOAD;
      S_LOAD:
        state_nxt = (b_q == '0) ? S_FIX : S_DIV;
      S_DIV:
        if (cnt == CW'(1)) state_nxt = S_FIX;
      S_FIX:
        state_nxt = S_DONE;
      S_DONE:
        if (bus.out_ready) state_nxt = S_IDLE;
      default:
        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      tag_q <= '0;
      mag_b <= '0;
      dvd   <= '0;
      rem   <= '0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_a <= 1'b0;
      dbz_q <= 1'b0;
      q_o   <= '0;
      r_o   <= '0;
      tag_o <= '0;
      dbz_o <= 1'b0;
      ovf_o <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.in_a;
            b_q   <= bus.in_b;
            tag_q <= bus.in_tag;
          end
        end
        S_LOAD: begin
          dvd   <= dvd_load;
          rem   <= '0;
          cnt   <= CW'(N);
          mag_b <= mag_b_c;
          neg_q <= a_neg_c ^ b_neg_c;
          neg_a <= a_neg_c;
          dbz_q <= (b_q == '0);
        end
        S_DIV: begin
          dvd <= {dvd[N-2:0], q_bit};
          rem <= rem_step;
          cnt <= cnt - CW'(1);
        end
        S_FIX: begin
          q_o   <= q_fix;
          r_o   <= r_fix;
          tag_o <= tag_q;
          dbz_o <= dbz_q;
          ovf_o <= ovf_fix;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.out_q     = q_o;
  assign bus.out_r     = r_o;
  assign bus.out_tag   = tag_o;
  assign bus.out_dbz   = dbz_o;
  assign bus.out_ovf   = ovf_o;

endmodule

// File: tb/tb_fxp_ratio_divider.sv
// Bench for fxp_ratio_divider: unsigned and signed
// instances share stimulus; checked against plain arithmetic.
module tb_fxp_ratio_divider;

  localparam int W  = 16;
  localparam int F  = 8;
  localparam int TW = 4;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
  } res_t;

  typedef struct packed {
    logic [TW-1:0] tag;
    res_t          res;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    res_t         eu;
    res_t         es;
    int           lat;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [TW-1:0] in_tag = '0;

  int   cyc = 0;
  int   c0 = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t exp_uq[$];
  exp_t exp_sq[$];
  vec_t vecs[16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fxp_ratio_divider_if #(.WIDTH(W), .TAG_W(TW)) u_if();
  fxp_ratio_divider_if #(.WIDTH(W), .TAG_W(TW)) s_if();

  assign u_if.in_valid  = in_valid;
  assign u_if.in_a      = in_a;
  assign u_if.in_b      = in_b;
  assign u_if.in_tag    = in_tag;
  assign u_if.out_ready = out_ready;
  assign s_if.in_valid  = in_valid;
  assign s_if.in_a      = in_a;
  assign s_if.in_b      = in_b;
  assign s_if.in_tag    = in_tag;
  assign s_if.out_ready = out_ready;

  fxp_ratio_divider #(
    .WIDTH(W), .FRAC_BITS(F), .SIGNED(0), .TAG_W(TW)
  ) u_dut (
    .clk(clk), .reset(reset), .bus(u_if)
  );

  fxp_ratio_divider #(
    .WIDTH(W), .FRAC_BITS(F), .SIGNED(1), .TAG_W(TW)
  ) s_dut (
    .clk(clk), .reset(reset), .bus(s_if)
  );

  function automatic res_t model_u(input logic [W-1:0] a,
                                   input logic [W-1:0] b);
    res_t   o;
    longint num, den, q, r;
    num = longint'({48'd0, a}) * 256;
    den = longint'({48'd0, b});
    o.dbz = (den == 0);
    o.ovf = 1'b0;
    if (den == 0) begin
      o.q = 16'hFFFF;
      o.r = a;
    end else begin
      q = num / den;
      r = num % den;
      o.ovf = (q >= 65536);
      o.q = o.ovf ? 16'hFFFF : q[15:0];
      o.r = r[15:0];
    end
    return o;
  endfunction

  function automatic res_t model_s(input logic [W-1:0] a,
                                   input logic [W-1:0] b);
    res_t   o;
    longint sa, sb, num, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    num = sa * 256;
    o.dbz = (sb == 0);
    o.ovf = 1'b0;
    if (sb == 0) begin
      o.q = (sa < 0) ? 16'h8000 : 16'h7FFF;
      o.r = a;
    end else begin
      q = num / sb;
      r = num % sb;
      o.ovf = (q > 32767) || (q < -32768);
      if (o.ovf) o.q = (q > 0) ? 16'h7FFF : 16'h8000;
      else       o.q = q[15:0];
      o.r = r[15:0];
    end
    return o;
  endfunction

  function automatic vec_t mk(
    input logic [W-1:0] a, b, uq, ur,
    input logic ud, uo,
    input logic [W-1:0] sq, sr,
    input logic sd, so);
    vec_t v;
    v.a = a;
    v.b = b;
    v.eu.q = uq; v.eu.r = ur;
    v.eu.dbz = ud; v.eu.ovf = uo;
    v.es.q = sq; v.es.r = sr;
    v.es.dbz = sd; v.es.ovf = so;
    v.lat = ud ? 2 : 26;
    return v;
  endfunction

  function automatic exp_t cur_u();
    return {u_if.out_tag, u_if.out_q, u_if.out_r,
            u_if.out_dbz, u_if.out_ovf};
  endfunction

  function automatic exp_t cur_s();
    return {s_if.out_tag, s_if.out_q, s_if.out_r,
            s_if.out_dbz, s_if.out_ovf};
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  task automatic send(input logic [W-1:0] a, b,
                      input logic [TW-1:0] tag,
                      input res_t eu, es);
    int k = 0;
    while (!(u_if.in_ready && s_if.in_ready) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 100) expire("send_wait");
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_tag = tag;
    exp_uq.push_back({tag, eu});
    exp_sq.push_back({tag, es});
    @(posedge clk); #1;
    c0 = cyc;
    in_valid = 1'b0;
    in_a = 16'($urandom);
    in_b = 16'($urandom);
    in_tag = 4'($urandom);
  endtask

  task automatic check_out();
    exp_t e;
    chk("busy_in_ready",
        64'({u_if.in_ready, s_if.in_ready}), 64'(0));
    chk("s_valid", 64'(s_if.out_valid), 64'(1));
    if (exp_uq.size() == 0 || exp_sq.size() == 0) begin
      expire("scoreboard_empty");
    end else begin
      e = exp_uq.pop_front();
      chk("u_result", 64'(cur_u()), 64'(e));
      e = exp_sq.pop_front();
      chk("s_result", 64'(cur_s()), 64'(e));
    end
  endtask

  task automatic recv(input int rdy_pct, output int lat);
    int k = 0;
    bit done = 0;
    lat = -1;
    while (!done && k < 400) begin
      if (u_if.out_valid && lat < 0) lat = cyc - c0;
      if (u_if.out_valid &&
          int'($urandom_range(99)) < rdy_pct) begin
        check_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("valid_drop",
            64'({u_if.out_valid, s_if.out_valid}), 64'(0));
        chk("ready_back",
            64'({u_if.in_ready, s_if.in_ready}), 64'(3));
        done = 1;
      end else begin
        @(posedge clk); #1;
        k++;
      end
    end
    if (!done) expire("recv_wait");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   k;
    bit   seen;
    res_t eu, es;
    logic [W-1:0] ra, rb;

    vecs[0]  = mk(16'h012C, 16'h0004, 16'h4B00, 16'h0000, 0, 0,
                  16'h4B00, 16'h0000, 0, 0);
    vecs[1]  = mk(16'h000A, 16'h0003, 16'h0355, 16'h0001, 0, 0,
                  16'h0355, 16'h0001, 0, 0);
    vecs[2]  = mk(16'h0007, 16'h0000, 16'hFFFF, 16'h0007, 1, 0,
                  16'h7FFF, 16'h0007, 1, 0);
    vecs[3]  = mk(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 0, 1,
                  16'hFF00, 16'h0000, 0, 0);
    vecs[4]  = mk(16'hFED4, 16'h0004, 16'hFFFF, 16'h0000, 0, 1,
                  16'hB500, 16'h0000, 0, 0);
    vecs[5]  = mk(16'h8000, 16'h0001, 16'hFFFF, 16'h0000, 0, 1,
                  16'h8000, 16'h0000, 0, 1);
    vecs[6]  = mk(16'hFFF9, 16'h0000, 16'hFFFF, 16'hFFF9, 1, 0,
                  16'h8000, 16'hFFF9, 1, 0);
    vecs[7]  = mk(16'hFFF6, 16'h0003, 16'hFFFF, 16'h0000, 0, 1,
                  16'hFCAB, 16'hFFFF, 0, 0);
    vecs[8]  = mk(16'h000A, 16'hFFFD, 16'h0000, 16'h0A00, 0, 0,
                  16'hFCAB, 16'h0001, 0, 0);
    vecs[9]  = mk(16'hFF80, 16'h0001, 16'hFFFF, 16'h0000, 0, 1,
                  16'h8000, 16'h0000, 0, 0);
    vecs[10] = mk(16'h0080, 16'h0001, 16'h8000, 16'h0000, 0, 0,
                  16'h7FFF, 16'h0000, 0, 1);
    vecs[11] = mk(16'h0000, 16'h0005, 16'h0000, 16'h0000, 0, 0,
                  16'h0000, 16'h0000, 0, 0);
    vecs[12] = mk(16'h00FF, 16'h00FF, 16'h0100, 16'h0000, 0, 0,
                  16'h0100, 16'h0000, 0, 0);
    vecs[13] = mk(16'h0001, 16'hFFFF, 16'h0000, 16'h0100, 0, 0,
                  16'hFF00, 16'h0000, 0, 0);
    vecs[14] = mk(16'hFFFF, 16'hFFFF, 16'h0100, 16'h0000, 0, 0,
                  16'h0100, 16'h0000, 0, 0);
    vecs[15] = mk(16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1, 0,
                  16'h7FFF, 16'h0000, 1, 0);

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst_in_ready",
        64'({u_if.in_ready, s_if.in_ready}), 64'(3));
    chk("rst_valid",
        64'({u_if.out_valid, s_if.out_valid}), 64'(0));
    chk("rst_u_outs", 64'(cur_u()), 64'(0));
    chk("rst_s_outs", 64'(cur_s()), 64'(0));

    for (int i = 0; i < 16; i++) begin
      send(vecs[i].a, vecs[i].b, 4'(i),
           vecs[i].eu, vecs[i].es);
      recv(100, lat);
      chk($sformatf("vec%0d_lat", i),
          64'(lat), 64'(vecs[i].lat));
    end

    // Backpressure: result held for ten cycles.
    eu = '{q: 16'h4B00, r: 16'h0, dbz: 1'b0, ovf: 1'b0};
    send(16'd300, 16'd4, 4'h9, eu, eu);
    k = 0;
    while (!u_if.out_valid && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 100) expire("bp_wait");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", 64'(cur_u()), 64'({4'h9, eu}));
      chk("bp_valid", 64'(u_if.out_valid), 64'(1));
      chk("bp_in_ready", 64'(u_if.in_ready), 64'(0));
    end
    recv(100, lat);
    chk("post_xfer_q", 64'(u_if.out_q), 64'(16'h4B00));
    chk("post_xfer_tag", 64'(u_if.out_tag), 64'(4'h9));

    // Reset while iterating aborts the operation.
    send(16'd300, 16'd4, 4'h3, eu, eu);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_uq.delete();
    exp_sq.delete();
    chk("abort_u_outs", 64'(cur_u()), 64'(0));
    chk("abort_s_outs", 64'(cur_s()), 64'(0));
    chk("abort_in_ready",
        64'({u_if.in_ready, s_if.in_ready}), 64'(3));
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (u_if.out_valid || s_if.out_valid) seen = 1;
    end
    chk("abort_no_valid", 64'(seen), 64'(0));
    send(16'd300, 16'd4, 4'h6, eu, eu);
    recv(100, lat);
    chk("after_abort_lat", 64'(lat), 64'(26));

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(5))
        0: rb = '0;
        1: rb = 16'($urandom_range(7));
        2: ra = 16'h8000;
        3: rb = 16'hFFFF;
        default: ;
      endcase
      repeat ($urandom_range(3)) begin
        @(posedge clk); #1;
      end
      eu = model_u(ra, rb);
      es = model_s(ra, rb);
      send(ra, rb, 4'(i), eu, es);
      recv(60, lat);
      chk("rand_lat", 64'(lat),
          64'((rb == '0) ? 2 : 26));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
